// File: rtl/ethernet_tx_queue.sv
// Transmit frame queue: payload and descriptor FIFOs feeding a byte-serial MAC stream.
// Define ETH_TX_PADDING_EN to zero-pad short frames to 60 bytes.
module ethernet_tx_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_DEPTH = 512,
  parameter int DESC_DEPTH    = 8,
  parameter int MAX_LENGTH    = 1500
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  payload_write_i,
  input  logic [DATA_WIDTH-1:0] payload_data_i,
  output logic                  payload_full_o,
  output logic                  payload_overflow_o,
  input  logic                  desc_write_i,
  input  logic [10:0]           desc_length_i,
  input  logic [47:0]           desc_mac_i,
  output logic                  desc_full_o,
  output logic                  desc_error_o,
  output logic                  mac_valid_o,
  input  logic                  mac_ready_i,
  output logic [7:0]            mac_data_o,
  output logic                  mac_last_o,
  output logic [10:0]           mac_length_o,
  output logic [47:0]           mac_dest_o,
  output logic                  busy_o,
  output logic                  irq_o,
  input  logic                  irq_ack_i,
  output logic [7:0]            done_count_o
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int BPW_M1 = BPW - 1;
  localparam int BW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int PAW    = $clog2(PAYLOAD_DEPTH);
  localparam int DAW    = $clog2(DESC_DEPTH);

  localparam logic [PAW:0]    PAY_FULL = PAYLOAD_DEPTH[PAW:0];
  localparam logic [DAW:0]    DSC_FULL = DESC_DEPTH[DAW:0];
  localparam logic [10:0]     MAX_LEN  = MAX_LENGTH[10:0];
  localparam logic [BW-1:0]   SEL_MAX  = BPW_M1[BW-1:0];

  typedef enum logic [1:0] {IDLE, WAIT_DATA, STREAM, DONE} state_t;
  state_t state, state_next;

  // Payload FIFO
  logic [DATA_WIDTH-1:0] pay_mem [PAYLOAD_DEPTH];
  logic [PAW-1:0]        pay_wr, pay_rd;
  logic [PAW:0]          pay_count, pay_count_next;
  logic                  pay_push, pay_pop;
  logic [DATA_WIDTH-1:0] head_word;

  assign pay_push  = payload_write_i & ~payload_full_o;
  assign head_word = pay_mem[pay_rd];

  always_ff @(posedge clk_i) begin
    if (pay_push) pay_mem[pay_wr] <= payload_data_i;
  end

  always_comb begin
    pay_count_next = pay_count;
    case ({pay_push, pay_pop})
      2'b10:   pay_count_next = pay_count + 1'b1;
      2'b01:   pay_count_next = pay_count - 1'b1;
      default: pay_count_next = pay_count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pay_wr             <= '0;
      pay_rd             <= '0;
      pay_count          <= '0;
      payload_full_o     <= 1'b0;
      payload_overflow_o <= 1'b0;
    end else begin
      if (pay_push) pay_wr <= pay_wr + 1'b1;
      if (pay_pop)  pay_rd <= pay_rd + 1'b1;
      pay_count          <= pay_count_next;
      payload_full_o     <= (pay_count_next == PAY_FULL);
      payload_overflow_o <= payload_write_i & payload_full_o;
    end
  end

  // Descriptor FIFO
  logic [10:0]    dsc_len_mem [DESC_DEPTH];
  logic [47:0]    dsc_mac_mem [DESC_DEPTH];
  logic [DAW-1:0] dsc_wr, dsc_rd;
  logic [DAW:0]   dsc_count, dsc_count_next;
  logic           dsc_len_ok, dsc_push, desc_pop, dsc_avail;
  logic [10:0]    head_len;
  logic [47:0]    head_mac;

  assign dsc_len_ok = (desc_length_i != 11'd0) && (desc_length_i <= MAX_LEN);
  assign dsc_push   = desc_write_i & ~desc_full_o & dsc_len_ok;
  assign dsc_avail  = (dsc_count != '0);
  assign head_len   = dsc_len_mem[dsc_rd];
  assign head_mac   = dsc_mac_mem[dsc_rd];

  always_ff @(posedge clk_i) begin
    if (dsc_push) begin
      dsc_len_mem[dsc_wr] <= desc_length_i;
      dsc_mac_mem[dsc_wr] <= desc_mac_i;
    end
  end

  always_comb begin
    dsc_count_next = dsc_count;
    case ({dsc_push, desc_pop})
      2'b10:   dsc_count_next = dsc_count + 1'b1;
      2'b01:   dsc_count_next = dsc_count - 1'b1;
      default: dsc_count_next = dsc_count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dsc_wr       <= '0;
      dsc_rd       <= '0;
      dsc_count    <= '0;
      desc_full_o  <= 1'b0;
      desc_error_o <= 1'b0;
    end else begin
      if (dsc_push) dsc_wr <= dsc_wr + 1'b1;
      if (desc_pop) dsc_rd <= dsc_rd + 1'b1;
      dsc_count    <= dsc_count_next;
      desc_full_o  <= (dsc_count_next == DSC_FULL);
      desc_error_o <= desc_write_i & ~dsc_push;
    end
  end

  // Frame datapath
  logic [10:0]   frame_len, byte_idx, last_idx, padded_len;
  logic [11:0]   words_needed;
  logic [BW-1:0] byte_sel;
  logic          enough, in_payload, word_end;

`ifdef ETH_TX_PADDING_EN
  assign padded_len = (head_len < 11'd60) ? 11'd60 : head_len;
`else
  assign padded_len = head_len;
`endif

  assign last_idx   = mac_length_o - 11'd1;
  assign enough     = 32'(pay_count) >= 32'(words_needed);
  assign in_payload = byte_idx < frame_len;
  // A word retires on its top byte or on the frame's final real byte (short last word).
  assign word_end   = (byte_sel == SEL_MAX) || (byte_idx == frame_len - 11'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_len    <= '0;
      mac_length_o <= '0;
      mac_dest_o   <= '0;
      words_needed <= '0;
      byte_idx     <= '0;
      byte_sel     <= '0;
    end else if (desc_pop) begin
      frame_len    <= head_len;
      mac_length_o <= padded_len;
      mac_dest_o   <= head_mac;
      words_needed <= ({1'b0, head_len} + 12'(BPW_M1)) / 12'(BPW);
      byte_idx     <= '0;
      byte_sel     <= '0;
    end else if (state == STREAM && mac_ready_i) begin
      byte_idx <= byte_idx + 11'd1;
      byte_sel <= (byte_sel == SEL_MAX) ? '0 : byte_sel + 1'b1;
    end
  end

  // FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (dsc_avail) state_next = WAIT_DATA;
      WAIT_DATA: if (enough) state_next = STREAM;
      STREAM:    if (mac_ready_i && byte_idx == last_idx) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    mac_valid_o = 1'b0;
    mac_last_o  = 1'b0;
    mac_data_o  = '0;
    busy_o      = 1'b0;
    desc_pop    = 1'b0;
    pay_pop     = 1'b0;
    case (state)
      IDLE:      desc_pop = dsc_avail;
      WAIT_DATA: busy_o = 1'b1;
      STREAM: begin
        busy_o      = 1'b1;
        mac_valid_o = 1'b1;
        mac_last_o  = (byte_idx == last_idx);
        if (in_payload) begin
          mac_data_o = head_word[{byte_sel, 3'b000} +: 8];
          pay_pop    = mac_ready_i & word_end;
        end
      end
      default: ;
    endcase
  end

  // Completion counter and interrupt; a DONE coinciding with ack restarts the count at 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o        <= 1'b0;
      done_count_o <= '0;
    end else if (state == DONE) begin
      irq_o <= 1'b1;
      if (irq_ack_i)                done_count_o <= 8'd1;
      else if (done_count_o != '1)  done_count_o <= done_count_o + 8'd1;
    end else if (irq_ack_i) begin
      irq_o        <= 1'b0;
      done_count_o <= '0;
    end
  end

endmodule

// File: tb/tb_ethernet_tx_queue.sv
// Directed bench for ethernet_tx_queue: byte order, latency, rejection, back-pressure and irq.
module tb_ethernet_tx_queue;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        payload_write_i = 1'b0;
  logic [31:0] payload_data_i = '0;
  logic        payload_full_o, payload_overflow_o;
  logic        desc_write_i = 1'b0;
  logic [10:0] desc_length_i = '0;
  logic [47:0] desc_mac_i = '0;
  logic        desc_full_o, desc_error_o;
  logic        mac_valid_o;
  logic        mac_ready_i = 1'b0;
  logic [7:0]  mac_data_o;
  logic        mac_last_o;
  logic [10:0] mac_length_o;
  logic [47:0] mac_dest_o;
  logic        busy_o, irq_o;
  logic        irq_ack_i = 1'b0;
  logic [7:0]  done_count_o;

  always #5 clk = ~clk;

  ethernet_tx_queue #(
    .DATA_WIDTH(32), .PAYLOAD_DEPTH(512), .DESC_DEPTH(8), .MAX_LENGTH(1500)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .payload_write_i(payload_write_i), .payload_data_i(payload_data_i),
    .payload_full_o(payload_full_o), .payload_overflow_o(payload_overflow_o),
    .desc_write_i(desc_write_i), .desc_length_i(desc_length_i), .desc_mac_i(desc_mac_i),
    .desc_full_o(desc_full_o), .desc_error_o(desc_error_o),
    .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i), .mac_data_o(mac_data_o),
    .mac_last_o(mac_last_o), .mac_length_o(mac_length_o), .mac_dest_o(mac_dest_o),
    .busy_o(busy_o), .irq_o(irq_o), .irq_ack_i(irq_ack_i), .done_count_o(done_count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Accepted bytes {last, data}, captured mid-cycle before the handshake edge
  logic [8:0]  rx_q[$];
  logic [8:0]  exp_q[$];
  logic [31:0] pq[$];
  int          lasts_seen = 0;

  always @(negedge clk) begin
    if (mac_valid_o && mac_ready_i) begin
      rx_q.push_back({mac_last_o, mac_data_o});
      if (mac_last_o) lasts_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    payload_write_i = 1'b1;
    payload_data_i  = w;
    tick();
    payload_write_i = 1'b0;
    pq.push_back(w);
  endtask

  task automatic push_desc(input logic [10:0] len, input logic [47:0] mac);
    desc_write_i  = 1'b1;
    desc_length_i = len;
    desc_mac_i    = mac;
    tick();
    desc_write_i  = 1'b0;
  endtask

  function automatic int exp_len(input int len);
`ifdef ETH_TX_PADDING_EN
    return (len < 60) ? 60 : len;
`else
    return len;
`endif
  endfunction

  task automatic expect_frame(input int len);
    int          el;
    logic [31:0] w;
    el = exp_len(len);
    w  = '0;
    for (int i = 0; i < el; i++) begin
      logic [7:0] b;
      b = 8'h00;
      if (i < len) begin
        if (i % 4 == 0) w = pq.pop_front();
        b = w[(i % 4) * 8 +: 8];
      end
      exp_q.push_back({(i == el - 1), b});
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check(tag, 64'(rx_q[i]), 64'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_lasts(input int target, input int budget);
    for (int c = 0; c < budget && lasts_seen < target; c++) tick();
    check("frames_done", 64'(lasts_seen), 64'(target));
  endtask

  task automatic ack_irq();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  int base;
  bit acked;

  initial begin
    // Reset state
    rst_i = 1'b1;
    repeat (2) tick();
    check("rst_flags", 64'({mac_valid_o, busy_o, irq_o, mac_last_o, payload_full_o,
                            desc_full_o, desc_error_o, payload_overflow_o}), 64'd0);
    check("rst_done_count", 64'(done_count_o), 64'd0);
    check("rst_length", 64'(mac_length_o), 64'd0);
    check("rst_dest", 64'(mac_dest_o), 64'd0);
    check("rst_data", 64'(mac_data_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Frame 1: 20 bytes 0x00..0x13, latency from descriptor write
    mac_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) push_word(32'h03020100 + 32'(k) * 32'h04040404);
    push_desc(11'd20, 48'h0A1B2C3D4E5F);
    check("lat_c1_valid", 64'(mac_valid_o), 64'd0);
    tick();
    check("lat_c2_valid", 64'(mac_valid_o), 64'd0);
    check("lat_c2_busy", 64'(busy_o), 64'd1);
    check("len_in_flight", 64'(mac_length_o), 64'(exp_len(20)));
    check("dest_in_flight", 64'(mac_dest_o), 64'h0A1B2C3D4E5F);
    tick();
    check("lat_c3_valid", 64'(mac_valid_o), 64'd1);
    check("first_byte", 64'(mac_data_o), 64'h00);
    expect_frame(20);
    wait_lasts(1, 200);
    tick();
    check("f1_irq", 64'(irq_o), 64'd1);
    check("f1_done_count", 64'(done_count_o), 64'd1);
    compare_stream("f1_bytes");

    // Frame 2: short last word, partial-word length 6
    ack_irq();
    check("ack_irq", 64'(irq_o), 64'd0);
    check("ack_count", 64'(done_count_o), 64'd0);
    push_word(32'hDDCCBBAA);
    push_word(32'h44332211);
    push_desc(11'd6, 48'h112233445566);
    expect_frame(6);
    wait_lasts(2, 200);
    tick();
    check("f2_byte0", 64'(rx_q[0][7:0]), 64'hAA);
    check("f2_byte5", 64'(rx_q[5][7:0]), 64'h22);
    compare_stream("f2_bytes");

    // Frame 3: waits for its second word, and holds under back-pressure
    push_word(32'h87654321);
    push_desc(11'd8, 48'hFFFFFFFFFFFF);
    repeat (4) tick();
    check("wait_busy", 64'(busy_o), 64'd1);
    check("wait_no_valid", 64'(mac_valid_o), 64'd0);
    mac_ready_i = 1'b0;
    push_word(32'h0FEDCBA9);
    check("push_edge_no_valid", 64'(mac_valid_o), 64'd0);
    tick();
    check("stream_start", 64'(mac_valid_o), 64'd1);
    check("hold_data0", 64'(mac_data_o), 64'h21);
    repeat (2) tick();
    check("hold_data1", 64'(mac_data_o), 64'h21);
    check("hold_valid", 64'(mac_valid_o), 64'd1);
    mac_ready_i = 1'b1;
    expect_frame(8);
    wait_lasts(3, 200);
    tick();
    compare_stream("f3_bytes");

    // Rejected descriptors
    ack_irq();
    push_desc(11'd0, 48'h0);
    check("err_len0", 64'(desc_error_o), 64'd1);
    tick();
    check("err_pulse_end", 64'(desc_error_o), 64'd0);
    push_desc(11'd1501, 48'h0);
    check("err_len1501", 64'(desc_error_o), 64'd1);
    repeat (4) tick();
    check("reject_not_busy", 64'(busy_o), 64'd0);

    // Descriptor FIFO fill: 10 writes, no payload
    base = lasts_seen;
    for (int i = 0; i < 10; i++) begin
      push_desc(11'd4, 48'(i));
      check("fill_err", 64'(desc_error_o), 64'(i == 9));
      check("fill_full", 64'(desc_full_o), 64'(i >= 8));
    end
    for (int k = 0; k < 9; k++) begin
      push_word(32'hC0DE0000 + 32'(k));
      expect_frame(4);
    end
    wait_lasts(base + 9, 3000);
    tick();
    check("fill_done_count", 64'(done_count_o), 64'd9);
    check("fill_full_clear", 64'(desc_full_o), 64'd0);
    compare_stream("fill_bytes");

    // Random back-pressure over 3 frames, ack during the 2nd DONE
    ack_irq();
    mac_ready_i = 1'b0;
    for (int k = 0; k < 7; k++) push_word(32'hA0A1A2A3 + 32'(k) * 32'h01010101);
    push_desc(11'd7, 48'h1);
    push_desc(11'd12, 48'h2);
    push_desc(11'd5, 48'h3);
    expect_frame(7);
    expect_frame(12);
    expect_frame(5);
    base  = lasts_seen;
    acked = 1'b0;
    for (int c = 0; c < 3000 && lasts_seen < base + 3; c++) begin
      mac_ready_i = ($urandom_range(0, 1) != 0);
      tick();
      if (lasts_seen == base + 2 && !acked) begin
        acked = 1'b1;
        check("rnd_count_pre_ack", 64'(done_count_o), 64'd1);
        irq_ack_i   = 1'b1;
        mac_ready_i = ($urandom_range(0, 1) != 0);
        tick();
        irq_ack_i = 1'b0;
        check("rnd_ack_in_done_count", 64'(done_count_o), 64'd1);
        check("rnd_ack_in_done_irq", 64'(irq_o), 64'd1);
      end
    end
    check("rnd_frames", 64'(lasts_seen), 64'(base + 3));
    tick();
    check("rnd_final_count", 64'(done_count_o), 64'd2);
    check("rnd_final_irq", 64'(irq_o), 64'd1);
    compare_stream("rnd_bytes");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
